bus_arbiter8: RTL and testbench

BUS_ARBITER8 -- requirements
Module: bus_arbiter8

---
 rtl/bus_arb_pkg.sv | 11 +
 rtl/bus_arbiter8_rr_pick8.sv | 29 ++
 rtl/bus_arbiter8.sv | 118 +++++++++++
 tb/tb_bus_arbiter8.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared sizes and FSM state type for the 8-way round-robin bus arbiter.
package bus_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_e;
endpackage

// File: rtl/bus_arbiter8_rr_pick8.sv
// Combinational round-robin pick: first set req bit at or after ptr, searching upward mod 8.
module rr_pick8
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    cand   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    onehot = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/bus_arbiter8.sv
// 8-requester round-robin bus arbiter (IDLE/BUSY/TURN) with registered one-hot grant.
// Optional grant hold limit enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter8
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             bus_valid,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter8: MAX_HOLD must be in 2..255");
  end

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             timeout_q, timeout_d;
  logic             hold_expired;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE && pick_any) begin
      hold_d = '0;
    end else if (state_q == BUSY) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= '0;
    else          hold_q <= hold_d;
  end

  // Last allowed BUSY cycle: hold_q counts BUSY cycles already completed.
  assign hold_expired = (state_q == BUSY) && (hold_q == 8'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          gnt_d   = pick_onehot;
          sel_d   = pick_idx;
          ptr_d   = pick_idx + SEL_W'(1);
        end
      end
      BUSY: begin
        // A release wins over a simultaneous expiry, so no pulse in that case.
        if (!req[sel_q]) begin
          state_d = TURN;
          gnt_d   = '0;
        end else if (hold_expired) begin
          state_d   = TURN;
          gnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      TURN: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = (state_q == BUSY);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed-vector and random-traffic bench for bus_arbiter8 (built with MAX_HOLD = 4).
module tb_bus_arbiter8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  bus_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
  } vec_t;

  vec_t vecs [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [7:0] eg, input logic [2:0] es,
                         input logic ev, input logic et);
    chk({name, ".gnt"}, 32'(gnt), 32'(eg));
    chk({name, ".sel"}, 32'(sel), 32'(es));
    chk({name, ".valid"}, 32'(bus_valid), 32'(ev));
    chk({name, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic step(input logic [7:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rq;
    int         hold_left [8];
    int         wait_cnt  [8];
    logic       prev_valid;
    logic [2:0] prev_sel;

    vecs[0]  = '{8'h01, 8'h01, 3'd0, 1'b1};
    vecs[1]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[3]  = '{8'h81, 8'h80, 3'd7, 1'b1};
    vecs[4]  = '{8'h81, 8'h80, 3'd7, 1'b1};
    vecs[5]  = '{8'h01, 8'h00, 3'd7, 1'b0};
    vecs[6]  = '{8'h81, 8'h00, 3'd7, 1'b0};
    vecs[7]  = '{8'h81, 8'h01, 3'd0, 1'b1};
    vecs[8]  = '{8'h80, 8'h00, 3'd0, 1'b0};
    vecs[9]  = '{8'h81, 8'h00, 3'd0, 1'b0};
    vecs[10] = '{8'h81, 8'h80, 3'd7, 1'b1};
    vecs[11] = '{8'h01, 8'h00, 3'd7, 1'b0};
    vecs[12] = '{8'h00, 8'h00, 3'd7, 1'b0};
    vecs[13] = '{8'h04, 8'h04, 3'd2, 1'b1};
    vecs[14] = '{8'h26, 8'h04, 3'd2, 1'b1};
    vecs[15] = '{8'h22, 8'h00, 3'd2, 1'b0};
    vecs[16] = '{8'h22, 8'h00, 3'd2, 1'b0};
    vecs[17] = '{8'h22, 8'h20, 3'd5, 1'b1};
    vecs[18] = '{8'h00, 8'h00, 3'd5, 1'b0};
    vecs[19] = '{8'h00, 8'h00, 3'd5, 1'b0};
    vecs[20] = '{8'h42, 8'h40, 3'd6, 1'b1};
    vecs[21] = '{8'h00, 8'h00, 3'd6, 1'b0};
    vecs[22] = '{8'h03, 8'h00, 3'd6, 1'b0};
    vecs[23] = '{8'h03, 8'h01, 3'd0, 1'b1};
    vecs[24] = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[25] = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[26] = '{8'h03, 8'h02, 3'd1, 1'b1};
    vecs[27] = '{8'h00, 8'h00, 3'd1, 1'b0};
    vecs[28] = '{8'h00, 8'h00, 3'd1, 1'b0};

    reset_n = 1'b0;
    req     = 8'h00;
    #12;
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      step(vecs[i].req);
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].valid, 1'b0);
    end

    // Reset in the middle of a grant drops the bus without a clock edge.
    step(8'h10);
    chk_out("pre_rst_busy", 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("held_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    req     = 8'h11;
    @(posedge clk);
    #1;
    chk_out("post_rst_favour0", 8'h01, 3'd0, 1'b1, 1'b0);
    step(8'h00);
    step(8'h00);

`ifdef BUS_ARB_TIMEOUT_EN
    step(8'h04);
    chk_out("to_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h04);
      chk_out($sformatf("to_hold%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step(8'h04);
    chk_out("to_pulse", 8'h00, 3'd2, 1'b0, 1'b1);
    step(8'h04);
    chk_out("to_idle", 8'h00, 3'd2, 1'b0, 1'b0);
    step(8'h04);
    chk_out("to_regrant_self", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h0c);
      chk_out($sformatf("to_hold_b%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step(8'h0c);
    chk_out("to_pulse_b", 8'h00, 3'd2, 1'b0, 1'b1);
    step(8'h0c);
    step(8'h0c);
    chk_out("to_next_req", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h0c);
      chk_out($sformatf("to_hold_c%0d", i), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    step(8'h04);
    chk_out("to_release_wins", 8'h00, 3'd3, 1'b0, 1'b0);
    step(8'h00);
    step(8'h00);
`else
    step(8'h04);
    chk_out("long_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(8'h04);
      chk_out($sformatf("long_hold%0d", i), 8'h04, 3'd2, 1'b1, 1'b0);
    end
    step(8'h00);
    chk_out("long_release", 8'h00, 3'd2, 1'b0, 1'b0);
    step(8'h00);
`endif

    // Random requesters that hold req until served for a short random time.
    rq         = 8'h00;
    prev_valid = 1'b0;
    prev_sel   = sel;
    for (int i = 0; i < 8; i++) begin
      hold_left[i] = 0;
      wait_cnt[i]  = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      chk("rand_onehot", 32'((gnt & (gnt - 8'd1)) == 8'd0), 32'd1);
      chk("rand_gnt_sel_valid", 32'(gnt[sel]), 32'(bus_valid));
      if (prev_valid && bus_valid) chk("rand_sel_stable", 32'(sel), 32'(prev_sel));
      if (bus_valid && !prev_valid) begin
        for (int i = 0; i < 8; i++) begin
          if (i == int'(sel)) begin
            wait_cnt[i] = 0;
          end else if (rq[i]) begin
            wait_cnt[i]++;
            chk($sformatf("rand_starve%0d", i), 32'(wait_cnt[i] <= 7), 32'd1);
          end
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (gnt[i]) begin
          if (hold_left[i] == 0) rq[i] = 1'b0;
          else                   hold_left[i]--;
        end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i]        = 1'b1;
          hold_left[i] = int'($urandom_range(0, 4));
          wait_cnt[i]  = 0;
        end
      end
      req        = rq;
      prev_valid = bus_valid;
      prev_sel   = sel;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
